// File: rtl/sha2_w_sched_param.sv
// SHA-2 message schedule generator.
// Loads one 16-word block and streams W_0..W_(ROUNDS-1) over a valid/ready
// handshake, producing W_16 onward from a sliding 16-entry window.
// WORD_W = 32 selects the SHA-256 sigma functions; WORD_W = 64 selects SHA-512.
module sha2_w_sched_param #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ROUNDS = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [16*WORD_W-1:0] block_in,
    output logic                 busy,
    output logic                 w_valid,
    input  logic                 w_ready,
    output logic [WORD_W-1:0]    w_out,
    output logic [6:0]           w_idx,
    output logic                 done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [6:0] LAST_IDX = 7'(ROUNDS - 1);

    // Rotate/shift amounts for the two sigma functions of the selected width.
    localparam int unsigned S0_R1 = (WORD_W == 64) ? 1  : 7;
    localparam int unsigned S0_R2 = (WORD_W == 64) ? 8  : 18;
    localparam int unsigned S0_SH = (WORD_W == 64) ? 7  : 3;
    localparam int unsigned S1_R1 = (WORD_W == 64) ? 19 : 17;
    localparam int unsigned S1_R2 = (WORD_W == 64) ? 61 : 19;
    localparam int unsigned S1_SH = (WORD_W == 64) ? 6  : 10;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] win_q [16];
    logic [WORD_W-1:0] win_d [16];
    logic [6:0]        t_q, t_d;
    logic [WORD_W-1:0] w_out_q, w_out_d;
    logic [6:0]        w_idx_q, w_idx_d;
    logic              w_valid_q, w_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WORD_W-1:0] new_word;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                               input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
        return rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
    endfunction

    function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
        return rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);
    endfunction

    // Next schedule word, entering the top of the window on each shift.
    always_comb begin
        new_word = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];
    end

    // Next-state logic: load on start in IDLE, shift on each accepted word in RUN.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        t_d       = t_q;
        w_out_d   = w_out_q;
        w_idx_d   = w_idx_q;
        w_valid_d = w_valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    for (int unsigned i = 0; i < 16; i++) begin
                        win_d[i] = block_in[(15 - i)*WORD_W +: WORD_W];
                    end
                    t_d       = '0;
                    w_out_d   = block_in[16*WORD_W-1 -: WORD_W];
                    w_idx_d   = '0;
                    w_valid_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (w_ready) begin
                    if (t_q == LAST_IDX) begin
                        // Final word accepted: window and outputs freeze in IDLE.
                        state_d   = IDLE;
                        w_valid_d = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < 15; i++) begin
                            win_d[i] = win_q[i + 1];
                        end
                        win_d[15] = new_word;
                        t_d       = t_q + 7'd1;
                        // w_out is registered, so it takes the entry about to become win[0].
                        w_out_d   = win_q[1];
                        w_idx_d   = t_q + 7'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            for (int unsigned i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
            t_q       <= '0;
            w_out_q   <= '0;
            w_idx_q   <= '0;
            w_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            t_q       <= t_d;
            w_out_q   <= w_out_d;
            w_idx_q   <= w_idx_d;
            w_valid_q <= w_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign w_valid = w_valid_q;
    assign w_out   = w_out_q;
    assign w_idx   = w_idx_q;
    assign done    = done_q;

endmodule
